// File: rtl/snn_lif_layer_seq.sv
// Time-multiplexed leaky-integrate-and-fire layer: one neuron evaluated per cycle, results published per step.
// Optional feature: define SNN_LAYER_SUBTRACT_RESET_EN for reset-by-subtraction on a spike (default reset-to-zero).
module snn_lif_layer_seq #(
  parameter int N_IN     = 8,
  parameter int N_OUT    = 8,
  parameter int W_BITS   = 2,
  parameter int V_BITS   = 6,
  parameter int REF_BITS = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            start,
  input  logic [N_IN-1:0]                 input_spikes,
  input  logic [N_IN*N_OUT*W_BITS-1:0]    weights,
  input  logic [V_BITS-1:0]               threshold,
  input  logic [V_BITS-1:0]               decay,
  input  logic [REF_BITS-1:0]             refractory_period,
  output logic                            busy,
  output logic                            done,
  output logic [N_OUT-1:0]                output_spikes,
  output logic [N_OUT*V_BITS-1:0]         membrane_potential_out
);

  localparam int SUM_W = V_BITS + $clog2(N_IN) + W_BITS + 1;
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                j_q, j_d;
  logic [N_IN-1:0]                 latched_q, latched_d;
  logic [N_OUT-1:0]                work_q, work_d;
  logic [N_OUT-1:0]                out_spk_q, out_spk_d;
  logic [N_OUT-1:0][V_BITS-1:0]    v_q, v_d;
  logic [N_OUT-1:0][REF_BITS-1:0]  ref_q, ref_d;

  logic signed [SUM_W-1:0]         syn_sum;
  logic signed [SUM_W-1:0]         vn_sum;
  logic [V_BITS-1:0]               v_cur, v_leak, vn, nxt_v;
  logic [REF_BITS-1:0]             ref_cur, nxt_ref;
  logic                            nxt_spk;

  // Clamp a signed accumulator into the unsigned potential range.
  function automatic logic [V_BITS-1:0] sat_v(input logic signed [SUM_W-1:0] x);
    if (x[SUM_W-1])
      sat_v = '0;
    else if (|x[SUM_W-2:V_BITS])
      sat_v = '1;
    else
      sat_v = x[V_BITS-1:0];
  endfunction

  function automatic logic [V_BITS-1:0] leak(input logic [V_BITS-1:0] v, input logic [V_BITS-1:0] d);
    leak = (v > d) ? v - d : '0;
  endfunction

  function automatic logic signed [SUM_W-1:0] sext_w(input logic [W_BITS-1:0] w);
    sext_w = {{(SUM_W-W_BITS){w[W_BITS-1]}}, w};
  endfunction

  function automatic logic [V_BITS-1:0] fire_v(input logic [V_BITS-1:0] v, input logic [V_BITS-1:0] thr);
`ifdef SNN_LAYER_SUBTRACT_RESET_EN
    fire_v = v - thr;
`else
    fire_v = '0;
    if (thr != thr) fire_v = v;
`endif
  endfunction

  // Synaptic sum of the currently selected neuron over all latched inputs.
  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (latched_q[i])
        syn_sum = syn_sum + sext_w(weights[(int'(j_q)*N_IN + i)*W_BITS +: W_BITS]);
    end
  end

  always_comb begin
    v_cur   = v_q[j_q];
    ref_cur = ref_q[j_q];
    v_leak  = leak(v_cur, decay);
    vn_sum  = $signed({{(SUM_W-V_BITS){1'b0}}, v_leak}) + syn_sum;
    vn      = sat_v(vn_sum);
    nxt_v   = vn;
    nxt_ref = ref_cur;
    nxt_spk = 1'b0;
    if (ref_cur != '0) begin
      nxt_ref = ref_cur - 1'b1;
      nxt_v   = '0;
    end else if (vn >= threshold) begin
      nxt_spk = 1'b1;
      nxt_ref = refractory_period;
      nxt_v   = fire_v(vn, threshold);
    end
  end

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    latched_d = latched_q;
    work_d    = work_q;
    out_spk_d = out_spk_q;
    v_d       = v_q;
    ref_d     = ref_q;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_RUN;
            latched_d = input_spikes;
            j_d       = '0;
            work_d    = '0;
          end
        end
        S_RUN: begin
          v_d[j_q]    = nxt_v;
          ref_d[j_q]  = nxt_ref;
          work_d[j_q] = nxt_spk;
          // Publish on entry to DONE so the spike vector is valid while done is high.
          if (j_q == LAST_IDX) begin
            state_d   = S_DONE;
            out_spk_d = work_d;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      j_q       <= '0;
      latched_q <= '0;
      work_q    <= '0;
      out_spk_q <= '0;
      v_q       <= '0;
      ref_q     <= '0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      latched_q <= latched_d;
      work_q    <= work_d;
      out_spk_q <= out_spk_d;
      v_q       <= v_d;
      ref_q     <= ref_d;
    end
  end

  assign busy                   = (state_q != S_IDLE);
  assign done                   = (state_q == S_DONE) && enable;
  assign output_spikes          = out_spk_q;
  assign membrane_potential_out = v_q;

endmodule

// File: tb/tb_snn_lif_layer_seq.sv
// Randomized and directed bench for snn_lif_layer_seq against an arithmetic LIF model.
module tb_snn_lif_layer_seq;
  localparam int NI = 8;
  localparam int NO = 8;
  localparam int WB = 2;
  localparam int VB = 6;
  localparam int RB = 6;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    enable = 1'b1;
  logic                    start = 1'b0;
  logic [NI-1:0]           input_spikes = '0;
  logic [NI*NO*WB-1:0]     weights = '0;
  logic [VB-1:0]           threshold = '0;
  logic [VB-1:0]           decay = '0;
  logic [RB-1:0]           refractory_period = '0;
  logic                    busy, done;
  logic [NO-1:0]           output_spikes;
  logic [NO*VB-1:0]        membrane_potential_out;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  int       mv [NO];
  int       mr [NO];
  logic [NO-1:0] ms;

  snn_lif_layer_seq #(.N_IN(NI), .N_OUT(NO), .W_BITS(WB), .V_BITS(VB), .REF_BITS(RB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .input_spikes(input_spikes), .weights(weights), .threshold(threshold),
    .decay(decay), .refractory_period(refractory_period),
    .busy(busy), .done(done), .output_spikes(output_spikes),
    .membrane_potential_out(membrane_potential_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wval(input int i, input int j);
    logic [WB-1:0] w;
    w = weights[(j*NI + i)*WB +: WB];
    return w[WB-1] ? int'(w) - (1 << WB) : int'(w);
  endfunction

  task automatic model_clear();
    for (int j = 0; j < NO; j++) begin mv[j] = 0; mr[j] = 0; end
    ms = '0;
  endtask

  task automatic model_step(input logic [NI-1:0] spk);
    int sum, vn;
    for (int j = 0; j < NO; j++) begin
      ms[j] = 1'b0;
      if (mr[j] != 0) begin
        mr[j] = mr[j] - 1;
        mv[j] = 0;
      end else begin
        sum = 0;
        for (int i = 0; i < NI; i++) if (spk[i]) sum += wval(i, j);
        vn = mv[j] - int'(decay);
        if (vn < 0) vn = 0;
        vn = vn + sum;
        if (vn < 0) vn = 0;
        if (vn > (1 << VB) - 1) vn = (1 << VB) - 1;
        if (vn >= int'(threshold)) begin
          ms[j] = 1'b1;
          mr[j] = int'(refractory_period);
`ifdef SNN_LAYER_SUBTRACT_RESET_EN
          mv[j] = vn - int'(threshold);
`else
          mv[j] = 0;
`endif
        end else begin
          mv[j] = vn;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [NO*VB-1:0] ev;
    for (int j = 0; j < NO; j++) ev[j*VB +: VB] = mv[j][VB-1:0];
    chk({tag, "_spk"}, 64'(output_spikes), 64'(ms));
    chk({tag, "_vmem"}, 64'(membrane_potential_out), 64'(ev));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One full step; returns the cycle (1 = first RUN cycle) at which done was seen.
  task automatic do_step(input string tag, input logic [NI-1:0] spk, input int stall_at,
                         input int stall_len, output int done_cyc);
    int c;
    input_spikes = spk;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_c1"}, 64'(busy), 64'(1));
    c = 1;
    while (!done && c < 60) begin
      if (c == stall_at) enable = 1'b0;
      if (c == stall_at + stall_len) enable = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    enable = 1'b1;
    done_cyc = c;
    chk({tag, "_done"}, 64'(done), 64'(1));
    model_step(spk);
    compare_model(tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int dc, prev, n;
    logic [NO-1:0] exp_spk;
    model_clear();

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_spk", 64'(output_spikes), 64'(0));
    chk("rst_vmem", 64'(membrane_potential_out), 64'(0));
    reset = 1'b0;

    // Accumulation with all weights +1.
    weights = {(NI*NO){2'b01}};
    threshold = 6'd20; decay = 6'd0; refractory_period = 6'd0;
    do_step("acc1", 8'hFF, 0, 0, dc);
    chk("acc1_lat", 64'(dc), 64'(NO + 1));
    chk("acc1_v0", 64'(membrane_potential_out[VB-1:0]), 64'(8));
    do_step("acc2", 8'hFF, 0, 0, dc);
    do_step("acc3", 8'hFF, 0, 0, dc);
    chk("acc3_all", 64'(output_spikes), 64'(8'hFF));

    // Reset in the middle of a step, then a fresh step.
    input_spikes = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_done", 64'(done), 64'(0));
    chk("mid_spk", 64'(output_spikes), 64'(0));
    chk("mid_vmem", 64'(membrane_potential_out), 64'(0));
    reset = 1'b0;
    model_clear();
    do_step("fresh", 8'hFF, 0, 0, dc);
    chk("fresh_lat", 64'(dc), 64'(NO + 1));

    // Refractory pattern.
    do_reset();
    threshold = 6'd1; refractory_period = 6'd2;
    for (int k = 0; k < 7; k++) begin
      do_step("refr", 8'h01, 0, 0, dc);
      exp_spk = (k % 3 == 0) ? 8'hFF : 8'h00;
      chk("refr_pat", 64'(output_spikes), 64'(exp_spk));
    end

    // Decay floor.
    do_reset();
    threshold = 6'd63; refractory_period = 6'd0; decay = 6'd0;
    do_step("dec_a", 8'h07, 0, 0, dc);
    decay = 6'd5;
    do_step("dec_b", 8'h00, 0, 0, dc);
    chk("dec_floor", 64'(membrane_potential_out), 64'(0));

    // Saturation to the top of the range and fire.
    do_reset();
    decay = 6'd0;
    for (int k = 0; k < 15; k++) do_step("sat_up", 8'h0F, 0, 0, dc);
    chk("sat_v60", 64'(membrane_potential_out[VB-1:0]), 64'(60));
    do_step("sat_top", 8'hFF, 0, 0, dc);
    chk("sat_fire", 64'(output_spikes), 64'(8'hFF));

    // Most negative weight on input 0 of neuron 0.
    do_reset();
    do_step("neg_a", 8'h0F, 0, 0, dc);
    weights[1:0] = 2'b10;
    do_step("neg_b", 8'h01, 0, 0, dc);
    chk("neg_v0", 64'(membrane_potential_out[VB-1:0]), 64'(2));
    chk("neg_nospk", 64'(output_spikes[0]), 64'(0));

    // Enable stall during RUN.
    do_step("stall", 8'h3C, 4, 3, dc);
    chk("stall_lat", 64'(dc), 64'(12));

    // start held high: one accepted step every N_OUT+2 cycles.
    threshold = 6'd20;
    input_spikes = 8'h0F; start = 1'b1;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      chk("held_done", 64'(done), 64'(1));
      model_step(input_spikes);
      compare_model("held");
      if (prev >= 0) chk("held_period", 64'(cyc_cnt - prev), 64'(NO + 2));
      prev = cyc_cnt;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("held_stop", 64'(busy), 64'(0));

    // Randomized steps with random configuration and stalls.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      int sa, sl;
      weights = {$urandom, $urandom, $urandom, $urandom};
      threshold = ($urandom_range(0, 7) == 0) ? 6'd0 : VB'($urandom_range(1, 63));
      decay = VB'($urandom_range(0, 7));
      refractory_period = RB'($urandom_range(0, 3));
      sa = $urandom_range(2, 8);
      sl = $urandom_range(0, 2);
      do_step("rnd", NI'($urandom), sa, sl, dc);
      chk("rnd_lat", 64'(dc), 64'(NO + 1 + sl));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc_cnt);
    $fatal(1, "timeout");
  end
endmodule
